afe_ro_buff_port_arb: RTL and testbench

- Shares the single-port transaction SRAM buffer between NUM_REQ AFE channels.
- Each channel has a write requester (incoming AFE samples) and a read requester (drain to the L2 path).
- Writes have priority so AFE samples are never dropped. A streak counter guarantees reads progress.
- Sits between the per-AFE top instances and the SRAM buffer macro. It issues at most one memory access per cycle and steers 1-cycle-latency read data back to the requester.

---
 rtl/afe_ro_buff_port_arb_if.sv | 35 +++
 rtl/afe_ro_buff_port_arb.sv | 129 ++++++++++++
 tb/tb_afe_ro_buff_port_arb.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/afe_ro_buff_port_arb_if.sv
// Requester-side and SRAM-side signal bundle of the transaction buffer port arbiter.
// The slave modport is the arbiter; the master modport is the AFE channels plus SRAM macro.
interface afe_ro_buff_port_arb_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int AWIDTH     = 10
);
  logic [NUM_REQ-1:0]                 wr_req_i;
  logic [NUM_REQ-1:0][AWIDTH-1:0]     wr_addr_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data_i;
  logic [NUM_REQ-1:0]                 wr_gnt_o;
  logic [NUM_REQ-1:0]                 rd_req_i;
  logic [NUM_REQ-1:0][AWIDTH-1:0]     rd_addr_i;
  logic [NUM_REQ-1:0]                 rd_gnt_o;
  logic [NUM_REQ-1:0]                 rd_rvalid_o;
  logic [DATA_WIDTH-1:0]              rd_rdata_o;
  logic                               mem_cen_o;
  logic                               mem_wen_o;
  logic [AWIDTH-1:0]                  mem_addr_o;
  logic [DATA_WIDTH-1:0]              mem_wdata_o;
  logic [DATA_WIDTH-1:0]              mem_rdata_i;
  logic                               starve_evt_o;

  modport slave (
    input  wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
    output wr_gnt_o, rd_gnt_o, rd_rvalid_o, rd_rdata_o,
    output mem_cen_o, mem_wen_o, mem_addr_o, mem_wdata_o, starve_evt_o
  );

  modport master (
    output wr_req_i, wr_addr_i, wr_data_i, rd_req_i, rd_addr_i, mem_rdata_i,
    input  wr_gnt_o, rd_gnt_o, rd_rvalid_o, rd_rdata_o,
    input  mem_cen_o, mem_wen_o, mem_addr_o, mem_wdata_o, starve_evt_o
  );
endinterface

// File: rtl/afe_ro_buff_port_arb.sv
// Single-port SRAM buffer arbiter for NUM_REQ AFE channels: writes first, round-robin
// within each class, with a write-streak limit that forces a pending read through.

// One round-robin lane: wins when it requests and nobody from ptr up to it does.
module afe_ro_buff_port_arb_lane #(
  parameter int NUM_REQ = 4,
  parameter int IDX     = 0,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               win
);
  localparam logic [PTR_W:0]   N_W   = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] IDX_W = PTR_W'(IDX);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             seen;
  logic             found;

  always_comb begin
    win   = 1'b0;
    seen  = 1'b0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(off);
      if (sum >= N_W) sum = sum - N_W;
      idx = sum[PTR_W-1:0];
      if (!found) begin
        if (idx == IDX_W) begin
          win   = req[IDX] & ~seen;
          found = 1'b1;
        end else begin
          seen = seen | req[idx];
        end
      end
    end
  end
endmodule

module afe_ro_buff_port_arb #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int AWIDTH        = 10,
  parameter int MAX_WR_STREAK = 8
) (
  input logic                      clk_i,
  input logic                      rst_i,
  afe_ro_buff_port_arb_if.slave    bus
);
  localparam int         PTR_W      = $clog2(NUM_REQ);
  localparam logic [7:0] STREAK_MAX = 8'(MAX_WR_STREAK);

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [7:0]            streak;
  logic [NUM_REQ-1:0]    wr_win, rd_win, wr_gnt, rd_gnt, rvalid_q;
  logic                  any_wr, any_rd, wr_cls, rd_cls, starve;
  logic [AWIDTH-1:0]     addr;
  logic [DATA_WIDTH-1:0] wdata;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    afe_ro_buff_port_arb_lane #(.NUM_REQ(NUM_REQ), .IDX(k), .PTR_W(PTR_W)) u_wr (
      .req(bus.wr_req_i), .ptr(wr_ptr), .win(wr_win[k])
    );
    afe_ro_buff_port_arb_lane #(.NUM_REQ(NUM_REQ), .IDX(k), .PTR_W(PTR_W)) u_rd (
      .req(bus.rd_req_i), .ptr(rd_ptr), .win(rd_win[k])
    );
  end

  // Class select: writes win unless the streak limit is reached with a read waiting.
  always_comb begin
    any_wr = |bus.wr_req_i;
    any_rd = |bus.rd_req_i;
    rd_cls = ~rst_i & any_rd & (~any_wr | (streak == STREAK_MAX));
    wr_cls = ~rst_i & any_wr & ~rd_cls;
    starve = rd_cls & any_wr;
    wr_gnt = wr_cls ? wr_win : '0;
    rd_gnt = rd_cls ? rd_win : '0;
  end

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    addr   = '0;
    wdata  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_gnt[k]) begin
        wr_nxt = (k == NUM_REQ-1) ? '0 : PTR_W'(k+1);
        addr   = addr  | bus.wr_addr_i[k];
        wdata  = wdata | bus.wr_data_i[k];
      end
      if (rd_gnt[k]) begin
        rd_nxt = (k == NUM_REQ-1) ? '0 : PTR_W'(k+1);
        addr   = addr | bus.rd_addr_i[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      streak   <= '0;
      rvalid_q <= '0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      rvalid_q <= rd_gnt;
      if ((|rd_gnt) || !any_rd)
        streak <= '0;
      else if ((|wr_gnt) && (streak != STREAK_MAX))
        streak <= streak + 8'd1;
    end
  end

  assign bus.wr_gnt_o     = wr_gnt;
  assign bus.rd_gnt_o     = rd_gnt;
  assign bus.starve_evt_o = starve;
  assign bus.mem_cen_o    = ~((|wr_gnt) | (|rd_gnt));
  assign bus.mem_wen_o    = ~(|wr_gnt);
  assign bus.mem_addr_o   = addr;
  assign bus.mem_wdata_o  = wdata;
  // Masked while reset is high so a read granted just before reset returns nothing.
  assign bus.rd_rvalid_o  = rst_i ? '0 : rvalid_q;
  assign bus.rd_rdata_o   = bus.mem_rdata_i;
endmodule

// File: tb/tb_afe_ro_buff_port_arb.sv
// Random plus directed stimulus for the buffer port arbiter, checked each cycle against
// a transaction-level model (round-robin pick, streak count, reference memory).
module tb_afe_ro_buff_port_arb;
  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int MAX = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  afe_ro_buff_port_arb_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .AWIDTH(AW)) bus ();

  afe_ro_buff_port_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .AWIDTH(AW), .MAX_WR_STREAK(MAX)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  always @(posedge clk) begin
    if (!bus.mem_cen_o) begin
      if (!bus.mem_wen_o) sram[bus.mem_addr_o] <= bus.mem_wdata_o;
      else                bus.mem_rdata_i      <= sram[bus.mem_addr_o];
    end
  end

  int n_chk = 0, n_fail = 0;
  int m_wr_ptr = 0, m_rd_ptr = 0, m_streak = 0;
  logic [N-1:0]  m_pend = '0;
  logic [DW-1:0] m_pend_data = '0;
  int last_wk = -1, last_rk = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int i = 0; i < N; i++)
      if (req[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  // Called just after the negedge with inputs stable; returns at the next negedge.
  task automatic step();
    int wk, rk;
    logic [N-1:0] one, ewg, erg;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewd;
    logic estv, any_rd;
    one = 1;
    wk = pick(bus.wr_req_i, m_wr_ptr);
    rk = pick(bus.rd_req_i, m_rd_ptr);
    any_rd = |bus.rd_req_i;
    ewg = '0; erg = '0; eaddr = '0; ewd = '0; estv = 1'b0;
    last_wk = -1; last_rk = -1;
    if (!rst) begin
      if (rk >= 0 && (wk < 0 || m_streak == MAX)) begin
        erg = one << rk; eaddr = bus.rd_addr_i[rk]; estv = (wk >= 0); last_rk = rk;
      end else if (wk >= 0) begin
        ewg = one << wk; eaddr = bus.wr_addr_i[wk]; ewd = bus.wr_data_i[wk]; last_wk = wk;
      end
    end
    #1;
    chk("wr_gnt", 64'(bus.wr_gnt_o), 64'(ewg));
    chk("rd_gnt", 64'(bus.rd_gnt_o), 64'(erg));
    chk("starve", 64'(bus.starve_evt_o), 64'(estv));
    chk("mem_cen", 64'(bus.mem_cen_o), 64'((ewg | erg) == '0));
    chk("mem_wen", 64'(bus.mem_wen_o), 64'(ewg == '0));
    if ((ewg | erg) != '0) chk("mem_addr", 64'(bus.mem_addr_o), 64'(eaddr));
    chk("mem_wdata", 64'(bus.mem_wdata_o), 64'(ewd));
    chk("rvalid", 64'(bus.rd_rvalid_o), rst ? 64'd0 : 64'(m_pend));
    if (!rst && m_pend != '0) chk("rdata", 64'(bus.rd_rdata_o), 64'(m_pend_data));
    @(posedge clk);
    if (rst) begin
      m_wr_ptr = 0; m_rd_ptr = 0; m_streak = 0; m_pend = '0;
    end else begin
      if (erg != '0 || !any_rd) m_streak = 0;
      else if (ewg != '0 && m_streak < MAX) m_streak++;
      if (ewg != '0) begin
        ref_mem[eaddr] = ewd;
        m_wr_ptr = (wk + 1) % N;
      end
      if (erg != '0) begin
        m_pend = erg; m_pend_data = ref_mem[eaddr];
        m_rd_ptr = (rk + 1) % N;
      end else m_pend = '0;
    end
    @(negedge clk);
  endtask

  task automatic rand_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < N; c++) begin
        if (!bus.wr_req_i[c] || last_wk == c) begin
          bus.wr_req_i[c]  = ($urandom_range(0, 2) != 0);
          bus.wr_addr_i[c] = AW'($urandom_range(0, 31));
          bus.wr_data_i[c] = $urandom;
        end
        if (!bus.rd_req_i[c] || last_rk == c) begin
          bus.rd_req_i[c]  = ($urandom_range(0, 1) != 0);
          bus.rd_addr_i[c] = AW'($urandom_range(0, 31));
        end
      end
      step();
    end
  endtask

  initial begin
    int nwr;
    bit got;
    logic [N-1:0] one;
    one = 1;
    for (int a = 0; a < (1 << AW); a++) begin
      sram[a] = $urandom; ref_mem[a] = sram[a];
    end
    bus.wr_req_i = '1; bus.rd_req_i = '1;
    for (int c = 0; c < N; c++) begin
      bus.wr_addr_i[c] = AW'(c); bus.wr_data_i[c] = DW'(c + 100); bus.rd_addr_i[c] = AW'(c + 8);
    end
    @(negedge clk);
    // Reset with every request asserted.
    for (int i = 0; i < 3; i++) begin
      #1 chk("rst_cen", 64'(bus.mem_cen_o), 64'd1);
      step();
    end
    rst = 1'b0; bus.rd_req_i = '0;
    #1 chk("rst_release", 64'(bus.wr_gnt_o), 64'b0001);
    step();
    // Write round-robin.
    for (int i = 0; i < 8; i++) begin
      #1 chk("wr_rr", 64'(bus.wr_gnt_o), 64'(one << ((i + 1) % N)));
      step();
    end
    // Anti-starvation.
    bus.wr_req_i = 4'b0011; bus.rd_req_i = 4'b0100; bus.rd_addr_i[2] = 10'h05A;
    nwr = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (bus.rd_gnt_o != '0) begin
        got = 1;
        chk("starve_gnt", 64'(bus.rd_gnt_o), 64'b0100);
        chk("starve_evt", 64'(bus.starve_evt_o), 64'd1);
        chk("starve_addr", 64'(bus.mem_addr_o), 64'h05A);
        chk("starve_nwr", 64'(nwr), 64'(MAX));
      end else nwr++;
      step();
      if (got) bus.rd_req_i = '0;
    end
    chk("starve_seen", 64'(got), 64'd1);
    #1 chk("starve_rvalid", 64'(bus.rd_rvalid_o), 64'b0100);
    chk("starve_rdata", 64'(bus.rd_rdata_o), 64'(ref_mem[10'h05A]));
    step();
    // Read-only traffic.
    bus.wr_req_i = '0; bus.rd_req_i = 4'b1010;
    bus.rd_addr_i[1] = 10'h011; bus.rd_addr_i[3] = 10'h033;
    for (int i = 0; i < 6; i++) step();
    // Reset right after a read grant.
    bus.rd_req_i = 4'b0010;
    #1 chk("mid_gnt", 64'(bus.rd_gnt_o), 64'b0010);
    step();
    rst = 1'b1; bus.rd_req_i = '0;
    #1 chk("mid_rvalid", 64'(bus.rd_rvalid_o), 64'd0);
    step();
    rst = 1'b0; bus.rd_req_i = '1;
    #1 chk("rd_ptr_rst", 64'(bus.rd_gnt_o), 64'b0001);
    step();
    // Write then read back.
    bus.rd_req_i = '0; bus.wr_req_i = 4'b1000;
    bus.wr_addr_i[3] = 10'h3FF; bus.wr_data_i[3] = 32'hDEADBEEF;
    step();
    bus.wr_req_i = '0; bus.rd_req_i = 4'b0001; bus.rd_addr_i[0] = 10'h3FF;
    step();
    bus.rd_req_i = '0;
    #1 chk("dint_rvalid", 64'(bus.rd_rvalid_o), 64'b0001);
    chk("dint_rdata", 64'(bus.rd_rdata_o), 64'hDEADBEEF);
    step();
    rand_traffic(400);
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
